// File: rtl/osd_pkg.sv
// osd_pkg
//   Shared types and helpers for the OSD test-pattern scheduler.
//   - state_t   : scheduler FSM states (S_IDLE, S_ORD0, S_ORD1, S_ORD2, S_FIN)
//   - ORDER_W   : width of a pattern order value
//   - osd_npat  : number of patterns emitted at order 2 for an information set of length k
package osd_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ORD0 = 3'd1,
      S_ORD1 = 3'd2,
      S_ORD2 = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam int ORDER_W = 2;

   // 1 (order-0) + k single flips + k choose 2 pair flips
   function automatic int osd_npat(input int k);
      return 1 + k + (k * (k - 1)) / 2;
   endfunction

endpackage

// File: rtl/osd_pair_counter.sv
// osd_pair_counter
//   Holds the bit-position counters i/j used to build flip masks. The same
//   counter serves the single-flip sweep (only i used) and the pair sweep
//   (i < j, lexicographic). The mask is registered alongside the counters.
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   clear_i  in   i=j=0, mask=0
//   load1_i  in   start single-flip sweep: i=0, mask=1<<0
//   load2_i  in   start pair sweep: i=0, j=1, mask=(1<<0)|(1<<1)
//   adv1_i   in   next single flip: i=i+1
//   adv2_i   in   next pair: j=j+1, or i=i+1 and j=i+2 when j is at K-1
//   mask_o   out  K-bit flip mask for the current position
//   last1_o  out  i is at the last single-flip position (K-1)
//   last2_o  out  (i,j) is the last pair (K-2, K-1)
module osd_pair_counter #(
   parameter int K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         load1_i,
   input  logic         load2_i,
   input  logic         adv1_i,
   input  logic         adv2_i,
   output logic [K-1:0] mask_o,
   output logic         last1_o,
   output logic         last2_o
);

   // One extra bit so i+2 / compares against K-1 never wrap.
   localparam int IW = $clog2(K) + 1;

   logic [IW-1:0] i_q, i_d;
   logic [IW-1:0] j_q, j_d;
   logic [K-1:0]  mask_q, mask_d;

   function automatic logic [K-1:0] bit_at(input logic [IW-1:0] pos);
      return K'(1) << pos;
   endfunction

   always_comb begin
      i_d    = i_q;
      j_d    = j_q;
      mask_d = mask_q;
      if (clear_i) begin
         i_d    = '0;
         j_d    = '0;
         mask_d = '0;
      end else if (load1_i) begin
         i_d    = '0;
         mask_d = bit_at('0);
      end else if (load2_i) begin
         i_d    = '0;
         j_d    = IW'(1);
         mask_d = bit_at('0) | bit_at(IW'(1));
      end else if (adv1_i) begin
         i_d    = i_q + IW'(1);
         mask_d = bit_at(i_d);
      end else if (adv2_i) begin
         if (j_q == IW'(K - 1)) begin
            i_d = i_q + IW'(1);
            j_d = i_q + IW'(2);
         end else begin
            j_d = j_q + IW'(1);
         end
         mask_d = bit_at(i_d) | bit_at(j_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q    <= '0;
         j_q    <= '0;
         mask_q <= '0;
      end else begin
         i_q    <= i_d;
         j_q    <= j_d;
         mask_q <= mask_d;
      end
   end

   assign mask_o  = mask_q;
   assign last1_o = (i_q == IW'(K - 1));
   assign last2_o = (i_q == IW'(K - 2)) && (j_q == IW'(K - 1));

endmodule

// File: rtl/osd_pattern_scheduler.sv
// osd_pattern_scheduler
//   Enumerates OSD test patterns for one decoding attempt: the order-0
//   pattern, all single-bit flips, then all bit-pair flips, up to a maximum
//   order latched at start. Patterns leave over a valid/ready stream; done
//   pulses for one cycle after the final transfer. All outputs registered.
// Optional feature macro: OSD_EARLY_STOP_EN (adds the stop input; stop=1 in
//   any emission cycle ends the run after any transfer of that cycle).
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a run (sampled only when idle)
//   max_order  in   highest order to emit (3 is treated as 2), latched on start
//   pat_valid  out  pattern outputs are valid
//   pat_ready  in   downstream accepts the pattern this cycle
//   flip_mask  out  K-bit flip mask
//   pat_order  out  order of the current pattern
//   pat_idx    out  running pattern index within the run
//   busy       out  run in progress (including the done cycle)
//   done       out  one-cycle completion pulse
//   stop       in   early-termination request (OSD_EARLY_STOP_EN only)
module osd_pattern_scheduler
   import osd_pkg::*;
#(
   parameter  int K    = 8,
   localparam int NPAT = osd_npat(K),
   localparam int CNTW = $clog2(NPAT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ORDER_W-1:0] max_order,
   output logic               pat_valid,
   input  logic               pat_ready,
   output logic [K-1:0]       flip_mask,
   output logic [ORDER_W-1:0] pat_order,
   output logic [CNTW-1:0]    pat_idx,
   output logic               busy,
`ifdef OSD_EARLY_STOP_EN
   input  logic               stop,
`endif
   output logic               done
);

   state_t             state_q, state_d;
   logic [ORDER_W-1:0] ord_max_q, ord_max_d;
   logic               valid_q, valid_d;
   logic [ORDER_W-1:0] order_q, order_d;
   logic [CNTW-1:0]    idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic cnt_clear, cnt_load1, cnt_load2, cnt_adv1, cnt_adv2;
   logic last1, last2;
   logic xfer, finish, stop_req;

`ifdef OSD_EARLY_STOP_EN
   assign stop_req = stop;
`else
   assign stop_req = 1'b0;
`endif

   assign xfer = valid_q & pat_ready;

   osd_pair_counter #(.K(K)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (cnt_clear),
      .load1_i (cnt_load1),
      .load2_i (cnt_load2),
      .adv1_i  (cnt_adv1),
      .adv2_i  (cnt_adv2),
      .mask_o  (flip_mask),
      .last1_o (last1),
      .last2_o (last2)
   );

   always_comb begin
      state_d   = state_q;
      ord_max_d = ord_max_q;
      valid_d   = valid_q;
      order_d   = order_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_clear = 1'b0;
      cnt_load1 = 1'b0;
      cnt_load2 = 1'b0;
      cnt_adv1  = 1'b0;
      cnt_adv2  = 1'b0;
      finish    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ORD0;
               ord_max_d = (max_order == 2'd3) ? 2'd2 : max_order;
               valid_d   = 1'b1;
               order_d   = 2'd0;
               idx_d     = '0;
               busy_d    = 1'b1;
               cnt_clear = 1'b1;
            end
         end
         S_ORD0, S_ORD1, S_ORD2: begin
            // Stop wins over advancing: the current transfer (if any) still
            // counts, but nothing further is presented.
            if (stop_req) begin
               finish = 1'b1;
            end else if (xfer) begin
               unique case (state_q)
                  S_ORD0: begin
                     if (ord_max_q != 2'd0) begin
                        state_d   = S_ORD1;
                        order_d   = 2'd1;
                        idx_d     = idx_q + CNTW'(1);
                        cnt_load1 = 1'b1;
                     end else begin
                        finish = 1'b1;
                     end
                  end
                  S_ORD1: begin
                     if (!last1) begin
                        idx_d    = idx_q + CNTW'(1);
                        cnt_adv1 = 1'b1;
                     end else if (ord_max_q == 2'd2) begin
                        state_d   = S_ORD2;
                        order_d   = 2'd2;
                        idx_d     = idx_q + CNTW'(1);
                        cnt_load2 = 1'b1;
                     end else begin
                        finish = 1'b1;
                     end
                  end
                  default: begin
                     if (!last2) begin
                        idx_d    = idx_q + CNTW'(1);
                        cnt_adv2 = 1'b1;
                     end else begin
                        finish = 1'b1;
                     end
                  end
               endcase
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (finish) begin
         state_d   = S_FIN;
         valid_d   = 1'b0;
         done_d    = 1'b1;
         cnt_clear = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ord_max_q <= '0;
         valid_q   <= 1'b0;
         order_q   <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ord_max_q <= ord_max_d;
         valid_q   <= valid_d;
         order_q   <= order_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign pat_valid = valid_q;
   assign pat_order = order_q;
   assign pat_idx   = idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
